// File: rtl/scan_sequencer.sv
// Channel scan sequencer driving a 3-to-8 decoder (sel/en) with a per-channel dwell.
// Optional freeze input enabled by defining SCAN_SEQ_PAUSE_EN.
module scan_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic [7:0] mask,
`ifdef SCAN_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic [2:0] sel,
  output logic       en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state, state_d;
  logic [2:0] ptr, ptr_d;
  logic [7:0] cnt, cnt_d;
  logic [7:0] mask_q, mask_d;
  logic       cont_q, cont_d;
  logic       hold;
  logic [2:0] sel_d;
  logic       en_d, busy_d, done_d;

`ifdef SCAN_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    mask_d  = mask_q;
    cont_d  = cont_q;
    case (state)
      IDLE: begin
        if (start && (mask != 8'h00)) begin
          state_d = SCAN;
          ptr_d   = 3'd0;
          cnt_d   = 8'd0;
          mask_d  = mask;
          cont_d  = continuous;
        end
      end
      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          ptr_d   = 3'd0;
          cnt_d   = 8'd0;
        end else if (!hold) begin
          if (mask_q[ptr] && (cnt != 8'(DWELL - 1))) begin
            cnt_d = cnt + 8'd1;
          end else begin
            // Disabled channels fall through here after a single cycle.
            cnt_d = 8'd0;
            ptr_d = ptr + 3'd1;
            if ((ptr == 3'd7) && !cont_q) begin
              state_d = DONE;
              ptr_d   = 3'd0;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that the registered copies line up with it.
  always_comb begin
    sel_d  = (state_d == SCAN) ? ptr_d : 3'd0;
    en_d   = (state_d == SCAN) && mask_d[ptr_d];
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 3'd0;
      cnt    <= 8'd0;
      mask_q <= 8'h00;
      cont_q <= 1'b0;
      sel    <= 3'd0;
      en     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      cnt    <= cnt_d;
      mask_q <= mask_d;
      cont_q <= cont_d;
      sel    <= sel_d;
      en     <= en_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: three instances (DWELL 4, 2, 1) share one stimulus set.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       continuous = 1'b0;
  logic [7:0] mask = 8'h00;
  logic       pause = 1'b0;

  logic [2:0] sel4, sel2, sel1;
  logic       en4, en2, en1, busy4, busy2, busy1, done4, done2, done1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous), .mask(mask),
`ifdef SCAN_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .sel(sel4), .en(en4), .busy(busy4), .done(done4));

  scan_sequencer #(.DWELL(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous), .mask(mask),
`ifdef SCAN_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .sel(sel2), .en(en2), .busy(busy2), .done(done2));

  scan_sequencer #(.DWELL(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous), .mask(mask),
`ifdef SCAN_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .sel(sel1), .en(en1), .busy(busy1), .done(done1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0; continuous = 1'b0; mask = 8'h00;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++;
    if ({sel4, en4, busy4, done4, sel2, en2, busy2, done2, sel1, en1, busy1, done1} !== 24'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {sel4, en4, busy4, done4, sel2, en2, busy2, done2, sel1, en1, busy1, done1});
    end
    do_reset();
  endtask

  task automatic test_full_sweep();
    mask = 8'hFF; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int ch = 0; ch < 8; ch++) begin
      for (int j = 0; j < 4; j++) begin
        total++;
        if (sel4 !== 3'(ch) || en4 !== 1'b1 || busy4 !== 1'b1 || done4 !== 1'b0) begin
          bad++;
          $display("FAIL full_sweep ch%0d cyc%0d: sel=%0d en=%b busy=%b done=%b want sel=%0d en=1 busy=1 done=0",
                   ch, j, sel4, en4, busy4, done4, ch);
        end
        tick();
      end
    end
    total++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || en4 !== 1'b0) begin
      bad++;
      $display("FAIL full_sweep_done: done=%b busy=%b en=%b want 1 0 0", done4, busy4, en4);
    end
    tick();
    total++;
    if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      bad++;
      $display("FAIL full_sweep_idle: done=%b busy=%b want 0 0", done4, busy4);
    end
  endtask

  task automatic test_skip_channels();
    logic [7:0] m;
    int scan_cycles;
    m = 8'b1000_0101;
    do_reset();
    mask = m; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    mask = 8'hFF;
    scan_cycles = 0;
    for (int ch = 0; ch < 8; ch++) begin
      for (int j = 0; j < (m[ch] ? 2 : 1); j++) begin
        total++;
        if (sel2 !== 3'(ch) || en2 !== m[ch] || busy2 !== 1'b1) begin
          bad++;
          $display("FAIL skip ch%0d cyc%0d: sel=%0d en=%b busy=%b want sel=%0d en=%b busy=1",
                   ch, j, sel2, en2, busy2, ch, m[ch]);
        end
        scan_cycles++;
        tick();
      end
    end
    total++;
    if (scan_cycles != 11 || done2 !== 1'b1 || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL skip_done: cycles=%0d done=%b busy=%b want 11 1 0", scan_cycles, done2, busy2);
    end
  endtask

  task automatic test_continuous_stop();
    logic saw_done;
    do_reset();
    mask = 8'h81; continuous = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; continuous = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (sel1 !== 3'(i % 8) || en1 !== ((i % 8) == 0 || (i % 8) == 7) || busy1 !== 1'b1) begin
        bad++;
        $display("FAIL continuous cyc%0d: sel=%0d en=%b busy=%b want sel=%0d", i, sel1, en1, busy1, i % 8);
      end
      if (done1) saw_done = 1'b1;
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (en1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || sel1 !== 3'd0) begin
      bad++;
      $display("FAIL stop: en=%b busy=%b done=%b sel=%0d want 0 0 0 0", en1, busy1, done1, sel1);
    end
    tick();
    total++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || saw_done !== 1'b0) begin
      bad++;
      $display("FAIL stop_no_done: done=%b busy=%b seen=%b want 0 0 0", done1, busy1, saw_done);
    end
  endtask

  task automatic test_start_stop_idle();
    do_reset();
    mask = 8'hFF; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total++;
    if (busy4 !== 1'b1 || en4 !== 1'b1 || sel4 !== 3'd0) begin
      bad++;
      $display("FAIL start_stop_idle: busy=%b en=%b sel=%0d want 1 1 0", busy4, en4, sel4);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    total++;
    if (busy4 !== 1'b0 || en4 !== 1'b0 || done4 !== 1'b0) begin
      bad++;
      $display("FAIL stop_in_scan: busy=%b en=%b done=%b want 0 0 0", busy4, en4, done4);
    end
  endtask

  task automatic test_zero_mask_and_busy_start();
    do_reset();
    mask = 8'h00; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || en4 !== 1'b0) begin
        bad++;
        $display("FAIL zero_mask cyc%0d: busy=%b done=%b en=%b want 0 0 0", i, busy4, done4, en4);
      end
    end
    start = 1'b0;
    tick();
    mask = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c == 6)  begin mask = 8'h00; continuous = 1'b1; start = 1'b1; end
      if (c == 10) begin start = 1'b0; mask = 8'h0F; end
      total++;
      if (sel4 !== 3'(c / 4) || en4 !== 1'b1 || busy4 !== 1'b1) begin
        bad++;
        $display("FAIL busy_start cyc%0d: sel=%0d en=%b busy=%b want sel=%0d en=1 busy=1",
                 c, sel4, en4, busy4, c / 4);
      end
      tick();
    end
    continuous = 1'b0;
    total++;
    if (done4 !== 1'b1 || busy4 !== 1'b0) begin
      bad++;
      $display("FAIL busy_start_done: done=%b busy=%b want 1 0", done4, busy4);
    end
    tick();
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    mask = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    total++;
    if (sel4 !== 3'd3 || en4 !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: sel=%0d en=%b want 3 1", sel4, en4);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (en4 !== 1'b0 || sel4 !== 3'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: en=%b sel=%0d busy=%b done=%b want 0 0 0 0", en4, sel4, busy4, done4);
    end
    #3 rst = 1'b0;
    tick();
    total++;
    if (done4 !== 1'b0 || busy4 !== 1'b0) begin
      bad++;
      $display("FAIL after_reset: done=%b busy=%b want 0 0", done4, busy4);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (sel4 !== 3'd0 || en4 !== 1'b1 || busy4 !== 1'b1) begin
      bad++;
      $display("FAIL restart: sel=%0d en=%b busy=%b want 0 1 1", sel4, en4, busy4);
    end
    repeat (4) tick();
    total++;
    if (sel4 !== 3'd1 || en4 !== 1'b1) begin
      bad++;
      $display("FAIL restart_ch1: sel=%0d en=%b want 1 1", sel4, en4);
    end
  endtask

`ifdef SCAN_SEQ_PAUSE_EN
  task automatic test_pause();
    do_reset();
    mask = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (sel4 !== 3'd2 || en4 !== 1'b1 || busy4 !== 1'b1) begin
        bad++;
        $display("FAIL pause_hold cyc%0d: sel=%0d en=%b busy=%b want 2 1 1", i, sel4, en4, busy4);
      end
    end
    pause = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (sel4 !== 3'd2 || en4 !== 1'b1) begin
        bad++;
        $display("FAIL pause_resume cyc%0d: sel=%0d en=%b want 2 1", i, sel4, en4);
      end
    end
    tick();
    total++;
    if (sel4 !== 3'd3 || en4 !== 1'b1) begin
      bad++;
      $display("FAIL pause_advance: sel=%0d en=%b want 3 1", sel4, en4);
    end
    pause = 1'b1; stop = 1'b1;
    tick();
    pause = 1'b0; stop = 1'b0;
    total++;
    if (busy4 !== 1'b0 || en4 !== 1'b0) begin
      bad++;
      $display("FAIL pause_stop: busy=%b en=%b want 0 0", busy4, en4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_sweep();
    test_skip_channels();
    test_continuous_stop();
    test_start_stop_idle();
    test_zero_mask_and_busy_start();
    test_reset_mid_scan();
`ifdef SCAN_SEQ_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, meaning the number of clock cycles en is held per enabled channel (legal 1..255).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request a scan, sampled on clk.
REQ-005 The block SHALL have port stop  input  1  abort an active scan, sampled on clk.
REQ-006 The block SHALL have port continuous  input  1  repeat mode, latched at accepted start.
REQ-007 The block SHALL have port mask  input  8  per-channel enable, bit i = channel i, latched at accepted start.
REQ-008 The block SHALL have port pause  input  1  freeze scan, present only when SCAN_SEQ_PAUSE_EN is defined.
REQ-009 The block SHALL have port sel  output  3  channel index, drives the 3-to-8 decoder select input.
REQ-010 The block SHALL have port en  output  1  channel strobe, drives the decoder enable.
REQ-011 The block SHALL have port busy  output  1  high while in SCAN state.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse at normal end of a single sweep.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 FSM SHALL have states IDLE, SCAN, DONE; a 3-bit pointer ptr and an 8-bit dwell counter.
REQ-015 IDLE: sel=0, en=0, busy=0, done=0; start=1 with mask!=0 at edge k SHALL latch mask/continuous, set ptr=0, enter SCAN so busy=1 from cycle k+1.
REQ-016 start with mask==0 SHALL be ignored (stay IDLE, no done); start while busy SHALL be ignored.
REQ-017 SCAN, latched mask[ptr]=1: sel=ptr, en=1 for exactly DWELL consecutive cycles, then ptr advances.
REQ-018 SCAN, latched mask[ptr]=0: channel SHALL take exactly 1 cycle with en=0, sel=ptr, then ptr advances.
REQ-019 Advance past ptr=7: continuous=1 SHALL wrap ptr to 0 and remain in SCAN with no gap cycle; continuous=0 SHALL enter DONE.
REQ-020 DONE SHALL last one cycle with done=1, en=0, busy=0, then return to IDLE.
REQ-021 stop=1 in SCAN SHALL force en=0, busy=0, IDLE at the next edge, with no done pulse; stop has priority over all other SCAN events.
REQ-022 start and stop high together in IDLE: start SHALL be accepted.
REQ-023 en SHALL never be high in IDLE or DONE; at most one channel is selected per cycle.
REQ-024 Changes to mask/continuous during SCAN SHALL have no effect until the next accepted start.

Reset
REQ-025 rst=1 SHALL immediately, independent of clk, force IDLE, ptr=0, dwell counter=0, sel=0, en=0, busy=0, done=0, latched mask=0.
REQ-026 Reset mid-scan SHALL abandon the scan with no done pulse; first start after rst release behaves as REQ-015.

Configuration
REQ-027 With macro SCAN_SEQ_PAUSE_EN defined, pause=1 in SCAN SHALL hold ptr, dwell counter, sel and en at current values; stop still overrides pause.
REQ-028 Without SCAN_SEQ_PAUSE_EN, port pause SHALL not exist and behaviour is REQ-001..026 unchanged.

Verification
REQ-029 DWELL=4, mask=8'hFF, continuous=0, start pulse -> sel 0..7 each with en=1 for 4 cycles (32 cycles), then done=1 for 1 cycle, busy=0.
REQ-030 DWELL=2, mask=8'b1000_0101, single sweep -> en high for sel=0,2,7 (2 cycles each), 5 skip cycles en=0, total 11 SCAN cycles then done.
REQ-031 continuous=1, mask=8'h81, DWELL=1 -> sel pattern 0,1..6 (en=0),7,0,... repeating with no gap cycle, done never asserted; stop -> en=0, busy=0 next cycle, no done.
REQ-032 mask=8'h00 start -> busy stays 0, done stays 0; start during busy -> sweep unaffected.
REQ-033 rst asserted mid-dwell at sel=3 -> en=0, sel=0, busy=0 before next clk edge; new start after release begins at sel=0.
REQ-034 SCAN_SEQ_PAUSE_EN defined, pause high 5 cycles mid-dwell at sel=2 -> sel=2, en=1 held; remaining dwell completes after pause drops.
